// File: rtl/simd_pkg.sv
// rtl/simd_pkg.sv - opcode constants and FSM state type for the SIMD vector engine
// Contents: OP_* opcode encodings for the 3-bit instruction field, state_t FSM states.
package simd_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_MAC = 3'b110;
    localparam logic [2:0] OP_ILL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/simd_out_fifo.sv
// rtl/simd_out_fifo.sv - result buffer between the compute stage and the output handshake
// Ports: clk, reset (async, active-high); push/push_data write side;
//   pop/pop_data read side (pop_data shows the head entry); count = occupancy, empty.
module simd_out_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    // Storage needs no reset: occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign pop_data = r_mem[r_rd_ptr];
    assign count    = r_count;
    assign empty    = (r_count == '0);

endmodule

// File: rtl/simd_vec_engine.sv
// rtl/simd_vec_engine.sv - SIMD vector engine: instruction FSM, per-lane ALUs, MAC accumulators
// Ports: clk, reset (async, active-high);
//   valid_instruction/instr_ready/instruction/data_size - vector command;
//   valid_data/data_ready/mc_data_in_opa/mc_data_in_opb - operand beats;
//   out_valid/out_ready/out_result/out_extra/out_last   - result beats;
//   busy (RUN or DRAIN), err (one-cycle pulse on a rejected command).
module simd_vec_engine
    import simd_pkg::*;
#(
    parameter int LANES      = 4,
    parameter int LANE_W     = 32,
    parameter int SIZE_W     = 6,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    valid_instruction,
    output logic                    instr_ready,
    input  logic [2:0]              instruction,
    input  logic [SIZE_W-1:0]       data_size,
    input  logic                    valid_data,
    output logic                    data_ready,
    input  logic [LANES*LANE_W-1:0] mc_data_in_opa,
    input  logic [LANES*LANE_W-1:0] mc_data_in_opb,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*LANE_W-1:0] out_result,
    output logic [LANES*LANE_W-1:0] out_extra,
    output logic                    out_last,
    output logic                    busy,
    output logic                    err
);
    localparam int VW = LANES * LANE_W;
    localparam int FW = 2 * VW + 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t            r_state;
    logic [2:0]        r_op;
    logic [SIZE_W-1:0] r_remaining;
    logic              r_err;
    logic              r_stage_valid;
    logic [VW-1:0]     r_stage_res;
    logic [VW-1:0]     r_stage_ext;
    logic              r_stage_last;

    logic [VW-1:0]     w_res;
    logic [VW-1:0]     w_ext;
    logic [CW-1:0]     w_count;
    logic              w_empty;
    logic [FW-1:0]     w_pop_data;
    logic              w_legal;
    logic              w_start;
    logic              w_beat;
    logic              w_is_last;
    logic              w_pop;

    assign w_legal   = (instruction != OP_ILL) && (data_size != '0);
    assign w_start   = (r_state == ST_IDLE) && valid_instruction && w_legal;
    assign w_beat    = data_ready && valid_data;
    assign w_is_last = (r_remaining == SIZE_W'(1));

    // Counting the in-flight compute stage guarantees a FIFO slot for every accepted beat.
    assign data_ready = (r_state == ST_RUN) &&
                        (({1'b0, w_count} + {{CW{1'b0}}, r_stage_valid}) < (CW+1)'(FIFO_DEPTH));

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [LANE_W-1:0]   w_a;
        logic [LANE_W-1:0]   w_b;
        logic [LANE_W:0]     w_add;
        logic [LANE_W:0]     w_sub;
        logic [2*LANE_W-1:0] w_mul;
        logic [2*LANE_W-1:0] w_mac;
        logic [2*LANE_W-1:0] r_acc;
        logic [LANE_W-1:0]   w_lres;
        logic [LANE_W-1:0]   w_lext;

        assign w_a   = mc_data_in_opa[g*LANE_W +: LANE_W];
        assign w_b   = mc_data_in_opb[g*LANE_W +: LANE_W];
        assign w_add = {1'b0, w_a} + {1'b0, w_b};
        // The extra top bit of the difference is the borrow.
        assign w_sub = {1'b0, w_a} - {1'b0, w_b};
        assign w_mul = {{LANE_W{1'b0}}, w_a} * {{LANE_W{1'b0}}, w_b};
        assign w_mac = r_acc + w_mul;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_acc <= '0;
            end else if (w_start) begin
                r_acc <= '0;
            end else if (w_beat && (r_op == OP_MAC)) begin
                r_acc <= w_mac;
            end
        end

        always_comb begin
            w_lres = '0;
            w_lext = '0;
            case (r_op)
                OP_ADD: begin w_lres = w_add[LANE_W-1:0]; w_lext = LANE_W'(w_add[LANE_W]); end
                OP_SUB: begin w_lres = w_sub[LANE_W-1:0]; w_lext = LANE_W'(w_sub[LANE_W]); end
                OP_AND: w_lres = w_a & w_b;
                OP_OR:  w_lres = w_a | w_b;
                OP_XOR: w_lres = w_a ^ w_b;
                OP_MUL: begin w_lres = w_mul[LANE_W-1:0]; w_lext = w_mul[2*LANE_W-1:LANE_W]; end
                OP_MAC: begin w_lres = w_mac[LANE_W-1:0]; w_lext = w_mac[2*LANE_W-1:LANE_W]; end
                default: ;
            endcase
        end

        assign w_res[g*LANE_W +: LANE_W] = w_lres;
        assign w_ext[g*LANE_W +: LANE_W] = w_lext;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_ADD;
            r_remaining <= '0;
            r_err       <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (valid_instruction) begin
                        if (!w_legal) begin
                            r_err <= 1'b1;
                        end else begin
                            r_op        <= instruction;
                            r_remaining <= data_size;
                            r_state     <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_beat) begin
                        r_remaining <= r_remaining - SIZE_W'(1);
                        if (w_is_last) r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!r_stage_valid && w_empty) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Compute stage: MAC only produces a beat for the final operand.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stage_valid <= 1'b0;
            r_stage_res   <= '0;
            r_stage_ext   <= '0;
            r_stage_last  <= 1'b0;
        end else if (w_beat) begin
            r_stage_valid <= (r_op != OP_MAC) || w_is_last;
            r_stage_res   <= w_res;
            r_stage_ext   <= w_ext;
            r_stage_last  <= w_is_last;
        end else begin
            r_stage_valid <= 1'b0;
        end
    end

    assign w_pop = out_valid && out_ready;

    simd_out_fifo #(
        .W     (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (r_stage_valid),
        .push_data ({r_stage_last, r_stage_ext, r_stage_res}),
        .pop       (w_pop),
        .pop_data  (w_pop_data),
        .count     (w_count),
        .empty     (w_empty)
    );

    assign instr_ready = (r_state == ST_IDLE);
    assign busy        = (r_state != ST_IDLE);
    assign err         = r_err;
    assign out_valid   = !w_empty;
    // Payload is forced to zero whenever no beat is presented.
    assign out_result  = out_valid ? w_pop_data[VW-1:0]    : '0;
    assign out_extra   = out_valid ? w_pop_data[2*VW-1:VW] : '0;
    assign out_last    = out_valid && w_pop_data[FW-1];

endmodule

// File: tb/tb_simd_vec_engine.sv
// tb/tb_simd_vec_engine.sv - self-checking bench for simd_vec_engine
module tb_simd_vec_engine;
    localparam int LANES  = 4;
    localparam int LANE_W = 32;
    localparam int SIZE_W = 6;
    localparam int DEPTH  = 4;
    localparam int VW     = LANES * LANE_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              valid_instruction;
    logic              instr_ready;
    logic [2:0]        instruction;
    logic [SIZE_W-1:0] data_size;
    logic              valid_data;
    logic              data_ready;
    logic [VW-1:0]     opa;
    logic [VW-1:0]     opb;
    logic              out_valid;
    logic              out_ready;
    logic [VW-1:0]     out_result;
    logic [VW-1:0]     out_extra;
    logic              out_last;
    logic              busy;
    logic              err;

    simd_vec_engine #(
        .LANES(LANES), .LANE_W(LANE_W), .SIZE_W(SIZE_W), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .valid_instruction(valid_instruction), .instr_ready(instr_ready),
        .instruction(instruction), .data_size(data_size),
        .valid_data(valid_data), .data_ready(data_ready),
        .mc_data_in_opa(opa), .mc_data_in_opb(opb),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_extra(out_extra), .out_last(out_last),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [VW-1:0] res;
        logic [VW-1:0] ext;
        logic          last;
        int            cyc;
    } beat_t;

    beat_t           exp_q[$];
    beat_t           got_q[$];
    beat_t           nb;
    int              phase;
    logic [2:0]      m_op;
    int              m_size;
    int              m_seen;
    longint unsigned mac_acc[LANES];
    bit              exp_err;
    bit              exp_dr;
    bit              exp_ov;
    bit              pre_empty;
    int              err_cnt;
    int              cyc;
    int              total;
    int              bad;
    int              ready_mode;
    logic [VW-1:0]   cr;
    logic [VW-1:0]   ce;

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference arithmetic per lane, straight from the opcode definitions.
    function automatic void calc(input logic [2:0] op, input logic [VW-1:0] a, input logic [VW-1:0] b,
                                 output logic [VW-1:0] r, output logic [VW-1:0] e);
        r = '0;
        e = '0;
        for (int i = 0; i < LANES; i++) begin
            longint unsigned x, y, p, s;
            x = 64'(a[i*LANE_W +: LANE_W]);
            y = 64'(b[i*LANE_W +: LANE_W]);
            p = x * y;
            case (op)
                3'd0: begin s = x + y; r[i*LANE_W +: LANE_W] = 32'(s); e[i*LANE_W +: LANE_W] = 32'(s >> 32); end
                3'd1: begin r[i*LANE_W +: LANE_W] = 32'(x - y); e[i*LANE_W +: LANE_W] = (x < y) ? 32'd1 : 32'd0; end
                3'd2: r[i*LANE_W +: LANE_W] = 32'(x & y);
                3'd3: r[i*LANE_W +: LANE_W] = 32'(x | y);
                3'd4: r[i*LANE_W +: LANE_W] = 32'(x ^ y);
                3'd5: begin r[i*LANE_W +: LANE_W] = 32'(p); e[i*LANE_W +: LANE_W] = 32'(p >> 32); end
                3'd6: begin
                    mac_acc[i] = mac_acc[i] + p;
                    r[i*LANE_W +: LANE_W] = 32'(mac_acc[i]);
                    e[i*LANE_W +: LANE_W] = 32'(mac_acc[i] >> 32);
                end
                default: ;
            endcase
        end
    endfunction

    // Compare process: checks every cycle, then advances the model to the next edge.
    initial begin
        phase = 0; exp_err = 0; err_cnt = 0; cyc = 0; m_seen = 0; m_size = 0; m_op = 3'd0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                chk("reset_ctl", VW'({out_valid, out_last, busy, err, data_ready, instr_ready}), VW'(6'b000001));
                chk("reset_res", out_result, '0);
                chk("reset_ext", out_extra, '0);
                exp_q.delete();
                phase = 0; exp_err = 0; m_seen = 0;
            end else begin
                exp_dr = (phase == 1) && (exp_q.size() < DEPTH);
                exp_ov = (exp_q.size() > 0) && (cyc >= exp_q[0].cyc + 2);
                chk_int("instr_ready", int'(instr_ready), int'(phase == 0));
                chk_int("busy", int'(busy), int'(phase != 0));
                chk_int("data_ready", int'(data_ready), int'(exp_dr));
                chk_int("err", int'(err), int'(exp_err));
                chk_int("out_valid", int'(out_valid), int'(exp_ov));
                if (err) err_cnt++;
                if (out_valid && exp_q.size() > 0) begin
                    chk("out_result", out_result, exp_q[0].res);
                    chk("out_extra", out_extra, exp_q[0].ext);
                    chk_int("out_last", int'(out_last), int'(exp_q[0].last));
                end
                pre_empty = (exp_q.size() == 0);
                exp_err = 0;
                if (out_valid && out_ready) begin
                    nb.res = out_result; nb.ext = out_extra; nb.last = out_last; nb.cyc = cyc;
                    got_q.push_back(nb);
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                end
                if (phase == 0 && valid_instruction) begin
                    if (instruction == 3'b111 || data_size == '0) begin
                        exp_err = 1;
                    end else begin
                        phase = 1; m_op = instruction; m_size = int'(data_size); m_seen = 0;
                        for (int i = 0; i < LANES; i++) mac_acc[i] = 0;
                    end
                end else if (phase == 1 && valid_data && exp_dr) begin
                    m_seen++;
                    calc(m_op, opa, opb, cr, ce);
                    if (m_op != 3'd6 || m_seen == m_size) begin
                        nb.res = cr; nb.ext = ce; nb.last = (m_seen == m_size); nb.cyc = cyc;
                        exp_q.push_back(nb);
                    end
                    if (m_seen == m_size) phase = 2;
                end else if (phase == 2 && pre_empty) begin
                    phase = 0;
                end
            end
        end
    end

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'($urandom_range(0, 1));
                1:       out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
        end
    end

    function automatic logic [VW-1:0] rnd_vec();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic issue(input logic [2:0] op, input int size);
        valid_instruction = 1'b1;
        instruction = op;
        data_size = SIZE_W'(size);
        @(posedge clk); #1;
        valid_instruction = 1'b0;
    endtask

    task automatic send_beats(input int n, input bit fixed, input logic [VW-1:0] a, input logic [VW-1:0] b);
        int sent;
        int guard;
        sent = 0;
        guard = 0;
        while (sent < n && guard < 2000) begin
            valid_data = fixed ? 1'b1 : ($urandom_range(0, 3) != 0);
            opa = fixed ? a : rnd_vec();
            opb = fixed ? b : rnd_vec();
            @(negedge clk);
            if (valid_data && data_ready) sent++;
            @(posedge clk); #1;
            guard++;
        end
        valid_data = 1'b0;
        chk_int("beats_sent", sent, n);
    endtask

    task automatic wait_idle(input int budget);
        int done;
        done = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (instr_ready && exp_q.size() == 0 && phase == 0) begin
                done = 1;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        chk_int("idle_reached", done, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        bit stalled;
        logic [2:0] op;
        int sz;
        total = 0; bad = 0; ready_mode = 2;
        reset = 1'b1; valid_instruction = 1'b0; instruction = 3'd0; data_size = '0;
        valid_data = 1'b0; opa = '0; opb = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // ADD wrap with carry
        got_q.delete();
        issue(3'd0, 1);
        send_beats(1, 1, {4{32'hffffffff}}, {4{32'h00000001}});
        wait_idle(100);
        chk_int("add_beats", got_q.size(), 1);
        if (got_q.size() > 0) begin
            chk("add_res", got_q[0].res, '0);
            chk("add_ext", got_q[0].ext, {4{32'h00000001}});
            chk_int("add_last", int'(got_q[0].last), 1);
        end

        // MUL full-width product
        got_q.delete();
        issue(3'd5, 1);
        send_beats(1, 1, {4{32'hffffffff}}, {4{32'hffffffff}});
        wait_idle(100);
        chk_int("mul_beats", got_q.size(), 1);
        if (got_q.size() > 0) begin
            chk("mul_res", got_q[0].res, {4{32'h00000001}});
            chk("mul_ext", got_q[0].ext, {4{32'hfffffffe}});
        end

        // MAC: three beats collapse into one
        got_q.delete();
        issue(3'd6, 3);
        send_beats(3, 1, {4{32'd2}}, {4{32'd3}});
        wait_idle(100);
        chk_int("mac_beats", got_q.size(), 1);
        if (got_q.size() > 0) begin
            chk("mac_res", got_q[0].res, {4{32'h12}});
            chk("mac_ext", got_q[0].ext, '0);
            chk_int("mac_last", int'(got_q[0].last), 1);
        end

        // Backpressure: FIFO plus stage hold exactly DEPTH beats
        got_q.delete();
        ready_mode = 1;
        issue(3'd0, 13);
        acc = 0;
        valid_data = 1'b1;
        for (int k = 0; k < 20; k++) begin
            opa = rnd_vec(); opb = rnd_vec();
            @(negedge clk);
            stalled = !data_ready;
            if (data_ready) acc++;
            @(posedge clk); #1;
            if (stalled) break;
        end
        repeat (3) @(posedge clk);
        #1 valid_data = 1'b0;
        chk_int("stall_after", acc, 4);
        ready_mode = 2;
        send_beats(9, 0, '0, '0);
        wait_idle(200);
        chk_int("bp_beats", got_q.size(), 13);
        if (got_q.size() == 13) begin
            chk_int("bp_last12", int'(got_q[12].last), 1);
            chk_int("bp_last11", int'(got_q[11].last), 0);
        end

        // Rejected commands
        got_q.delete();
        err_cnt = 0;
        issue(3'd7, 5);
        repeat (2) @(posedge clk);
        #1;
        issue(3'd0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk_int("err_pulses", err_cnt, 2);
        chk_int("err_no_out", got_q.size(), 0);
        chk_int("err_idle", int'(instr_ready), 1);

        // Reset in the middle of a vector
        issue(3'd0, 8);
        send_beats(3, 0, '0, '0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk_int("post_reset_ready", int'(instr_ready), 1);
        chk_int("post_reset_valid", int'(out_valid), 0);
        @(posedge clk); #1;
        got_q.delete();
        issue(3'd0, 1);
        send_beats(1, 1, {4{32'd5}}, {4{32'd7}});
        wait_idle(100);
        chk_int("rst_add_beats", got_q.size(), 1);
        if (got_q.size() > 0) chk("rst_add_res", got_q[0].res, {4{32'd12}});

        // Randomized vectors against the model
        ready_mode = 0;
        for (int v = 0; v < 40; v++) begin
            op = 3'($urandom_range(0, 7));
            sz = $urandom_range(0, 8);
            issue(op, sz);
            if (op != 3'd7 && sz != 0) send_beats(sz, 0, '0, '0);
            wait_idle(300);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
